uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of a start/data/parity/stop serializer.
// Bit timer restarts at every frame start, so the first (start) bit is always a full bit period.
module uart_tx_fifo #(
    parameter int unsigned MAIN_CLK   = 120000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          uart_tx
);

    localparam int unsigned BAUD_DIVIDE = MAIN_CLK / BAUD;
    localparam int unsigned CNT_W       = $clog2(BAUD_DIVIDE);
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W       = PTR_W + 1;
    localparam int unsigned IDX_W       = 4;

    if ((BAUD_DIVIDE < 2) || (DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY > 2) ||
        (STOP_BITS < 1) || (STOP_BITS > 2) || (FIFO_DEPTH < 2) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_cfg_check
        $error("uart_tx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_ready;
    logic [LVL_W-1:0]       r_level;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];

    logic                   w_push;
    logic                   w_pop;
    logic                   w_bit_done;
    logic                   w_last_data;
    logic                   w_last_stop;
    logic [DATA_BITS-1:0]   w_head;
    logic                   w_head_par;
    logic [LVL_W-1:0]       w_level_nxt;

    assign w_bit_done  = (r_cnt == CNT_W'(BAUD_DIVIDE - 1));
    assign w_last_data = (r_idx == IDX_W'(DATA_BITS - 1));
    assign w_last_stop = (r_idx == IDX_W'(STOP_BITS - 1));
    assign w_push      = tx_valid && r_ready;

    // A frame starts (and the head is popped) from IDLE, or straight out of the last stop bit.
    assign w_pop       = (r_level != '0) &&
                         ((r_state == S_IDLE) ||
                          ((r_state == S_STOP) && w_bit_done && w_last_stop));

    assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_par  = (^w_head) ^ (PARITY == 2);

    assign tx_ready    = r_ready;
    assign tx_busy     = r_busy;
    assign fifo_level  = r_level;
    assign uart_tx     = r_tx;

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt != LVL_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (w_pop) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= w_head;
            r_par   <= w_head_par;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_cnt <= '0;
                        if (w_last_data) begin
                            r_idx <= '0;
                            if (PARITY != 0) begin
                                r_tx    <= r_par;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_cnt <= '0;
                        if (w_last_stop) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_tx    <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations (8N1, 8E1, 8O1, 5N2) at 4 clocks per bit,
// checked every cycle against a frame-timeline model plus hand-computed waveforms.
module tb_uart_tx_fifo;

    localparam int NI    = 4;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid [NI];
    logic [8:0] data  [NI];
    logic       rdy   [NI];
    logic       busy  [NI];
    logic       line  [NI];
    logic [2:0] lvl   [NI];

    int vectors     = 0;
    int miscompares = 0;

    // Model: queue of accepted characters and a cycle timeline for the frame on the wire.
    logic [8:0] m_buf [NI][64];
    int         m_head [NI];
    int         m_tail [NI];
    int         m_t    [NI];
    bit         m_act  [NI];
    bit         m_acc  [NI];
    logic [8:0] m_cur  [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned DB  = (g == 3) ? 5 : 8;
        localparam int unsigned PAR = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
        localparam int unsigned SB  = (g == 3) ? 2 : 1;
        uart_tx_fifo #(
            .MAIN_CLK   (1000000),
            .BAUD       (250000),
            .DATA_BITS  (DB),
            .PARITY     (PAR),
            .STOP_BITS  (SB),
            .FIFO_DEPTH (DEPTH)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .tx_valid   (valid[g]),
            .tx_ready   (rdy[g]),
            .tx_data    (data[g][DB-1:0]),
            .tx_busy    (busy[g]),
            .fifo_level (lvl[g]),
            .uart_tx    (line[g])
        );
    end

    function automatic int db_of(int k);
        return (k == 3) ? 5 : 8;
    endfunction

    function automatic int par_of(int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction

    function automatic int sb_of(int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int len_of(int k);
        return DIV * (1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k));
    endfunction

    // Line level of bit slot idx in the frame carrying character c.
    function automatic logic exp_bit(int k, logic [8:0] c, int idx);
        int db;
        db = db_of(k);
        if (idx == 0) return 1'b0;
        if (idx <= db) return c[idx-1];
        if ((par_of(k) != 0) && (idx == db + 1)) return (par_of(k) == 1) ? ^c : ~^c;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            m_head[k] = 0;
            m_tail[k] = 0;
            m_t[k]    = 0;
            m_act[k]  = 1'b0;
            m_acc[k]  = 1'b0;
            m_cur[k]  = '0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            int cnt;
            logic [8:0] mask;
            cnt      = m_tail[k] - m_head[k];
            mask     = 9'((1 << db_of(k)) - 1);
            m_acc[k] = 1'b0;
            if (m_act[k]) begin
                m_t[k]++;
                if (m_t[k] >= len_of(k)) m_act[k] = 1'b0;
            end
            if (!m_act[k] && cnt > 0) begin
                m_cur[k] = m_buf[k][m_head[k] % 64];
                m_head[k]++;
                m_act[k] = 1'b1;
                m_t[k]   = 0;
            end
            if (valid[k] && cnt < DEPTH) begin
                m_buf[k][m_tail[k] % 64] = data[k] & mask;
                m_tail[k]++;
                m_acc[k] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            logic e_line;
            int   e_lvl;
            e_line = m_act[k] ? exp_bit(k, m_cur[k], m_t[k] / DIV) : 1'b1;
            e_lvl  = m_tail[k] - m_head[k];
            chk($sformatf("uart_tx[%0d]", k), int'(line[k]), int'(e_line));
            chk($sformatf("tx_busy[%0d]", k), int'(busy[k]), int'(m_act[k]));
            chk($sformatf("fifo_level[%0d]", k), int'(lvl[k]), e_lvl);
            chk($sformatf("tx_ready[%0d]", k), int'(rdy[k]), (e_lvl < DEPTH) ? 1 : 0);
        end
    endtask

    // One clock: model follows the rising edge, outputs are compared on the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        if (!reset_n) model_clear();
        compare_all();
    endtask

    task automatic push(input int k, input logic [8:0] d);
        valid[k] = 1'b1;
        data[k]  = d;
        step();
        valid[k] = 1'b0;
    endtask

    // Assert reset shortly after a rising edge and check that outputs respond without a clock.
    task automatic reset_mid();
        @(posedge clk);
        if (reset_n) model_edge();
        #1 reset_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("async_rst_line[%0d]", k), int'(line[k]), 1);
            chk($sformatf("async_rst_busy[%0d]", k), int'(busy[k]), 0);
            chk($sformatf("async_rst_level[%0d]", k), int'(lvl[k]), 0);
            chk($sformatf("async_rst_ready[%0d]", k), int'(rdy[k]), 1);
        end
        @(negedge clk);
        model_clear();
        compare_all();
    endtask

    logic        s_line [NI][48];
    logic        s_busy [NI][48];
    logic [10:0] pat    [NI];
    int          nb     [NI];

    initial begin
        int   idx;
        int   n;
        int   max_lvl;
        int   busy_cnt;
        int   falls;
        int   zeros;
        logic prev_busy;
        logic [8:0] chars [6];

        reset_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            valid[k] = 1'b0;
            data[k]  = '0;
        end
        model_clear();

        // Reset state
        repeat (3) step();
        chk("reset_line0", int'(line[0]), 1);
        chk("reset_ready3", int'(rdy[3]), 1);
        chk("reset_level1", int'(lvl[1]), 0);
        reset_n = 1'b1;
        repeat (2) step();

        // Single frame on each configuration
        pat[0] = 11'b00_1010101010;   nb[0] = 10;
        pat[1] = 11'b11000001110;     nb[1] = 11;
        pat[2] = 11'b10000001110;     nb[2] = 11;
        pat[3] = 11'b000_11111110;    nb[3] = 8;
        data[0] = 9'h055;
        data[1] = 9'h007;
        data[2] = 9'h007;
        data[3] = 9'h01F;
        for (int k = 0; k < NI; k++) valid[k] = 1'b1;
        step();
        for (int k = 0; k < NI; k++) begin
            valid[k] = 1'b0;
            chk($sformatf("accept_line[%0d]", k), int'(line[k]), 1);
            chk($sformatf("accept_level[%0d]", k), int'(lvl[k]), 1);
        end
        for (int s = 0; s < 48; s++) begin
            for (int k = 0; k < NI; k++) data[k] = 9'($urandom);
            step();
            for (int k = 0; k < NI; k++) begin
                s_line[k][s] = line[k];
                s_busy[k][s] = busy[k];
            end
        end
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("latency_start[%0d]", k), int'(s_line[k][0]), 0);
            for (int i = 0; i < nb[k]; i++) begin
                for (int j = 0; j < DIV; j++) begin
                    chk($sformatf("frame%0d_bit%0d_c%0d", k, i, j),
                        int'(s_line[k][4*i+j]), int'(pat[k][i]));
                end
            end
            chk($sformatf("busy_last[%0d]", k), int'(s_busy[k][4*nb[k]-1]), 1);
            chk($sformatf("busy_fall[%0d]", k), int'(s_busy[k][4*nb[k]]), 0);
        end

        // Six characters held on tx_valid: FIFO fills, frames run back to back
        chars[0] = 9'h03C; chars[1] = 9'h0C3; chars[2] = 9'h000;
        chars[3] = 9'h0FF; chars[4] = 9'h081; chars[5] = 9'h05A;
        idx = 0; n = 0; max_lvl = 0; busy_cnt = 0; falls = 0; prev_busy = 1'b0;
        while ((idx < 6 || m_act[0] || m_tail[0] != m_head[0]) && n < 600) begin
            valid[0] = (idx < 6);
            data[0]  = (idx < 6) ? chars[idx] : 9'($urandom);
            step();
            if (m_acc[0]) idx++;
            if (int'(lvl[0]) > max_lvl) max_lvl = int'(lvl[0]);
            if (busy[0]) busy_cnt++;
            if (prev_busy && !busy[0]) falls++;
            prev_busy = busy[0];
            n++;
        end
        valid[0] = 1'b0;
        chk("fill_all_accepted", idx, 6);
        chk("fill_max_level", max_lvl, 4);
        chk("b2b_busy_cycles", busy_cnt, 240);
        chk("b2b_busy_falls", falls, 1);

        // Simultaneous push and pop at level 2
        push(3, 9'h00A);
        push(3, 9'h015);
        push(3, 9'h003);
        chk("pushpop_level_pre", int'(lvl[3]), 2);
        n = 0;
        while (!(m_act[3] && m_t[3] == len_of(3) - 1) && n < 100) begin
            step();
            n++;
        end
        chk("pushpop_reached", (n < 100) ? 1 : 0, 1);
        valid[3] = 1'b1;
        data[3]  = 9'h011;
        step();
        valid[3] = 1'b0;
        chk("pushpop_level", int'(lvl[3]), 2);
        chk("pushpop_line_start", int'(line[3]), 0);
        n = 0;
        while ((m_act[3] || m_tail[3] != m_head[3]) && n < 400) begin
            step();
            n++;
        end
        chk("pushpop_drained", (n < 400) ? 1 : 0, 1);

        // Reset mid data bit with three characters queued
        push(0, 9'h0A5);
        push(0, 9'h011);
        push(0, 9'h022);
        push(0, 9'h033);
        chk("rst_level_pre", int'(lvl[0]), 3);
        repeat (10) step();
        chk("rst_busy_pre", int'(busy[0]), 1);
        reset_mid();
        repeat (2) step();
        reset_n = 1'b1;
        zeros = 0;
        repeat (60) begin
            step();
            if (!line[0]) zeros++;
        end
        chk("rst_line_quiet", zeros, 0);
        chk("rst_level_post", int'(lvl[0]), 0);

        // First edge after reset release accepts a character
        reset_mid();
        step();
        reset_n  = 1'b1;
        valid[0] = 1'b1;
        data[0]  = 9'h096;
        step();
        valid[0] = 1'b0;
        chk("first_edge_accept", int'(lvl[0]), 1);
        step();
        chk("first_edge_start", int'(line[0]), 0);
        repeat (50) step();
        chk("final_idle_line", int'(line[0]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
